// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } arb_port_e;

  localparam int unsigned ROM_LATENCY = 1;
  localparam int unsigned WORD_BYTES  = 4;

  // True when a word access at addr is misaligned or runs past the ROM end.
  // The sum is widened so addresses near 2^32 cannot wrap into range.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned rom_size);
    logic [32:0] last_byte;
    last_byte = {1'b0, addr} + 33'(WORD_BYTES - 1);
    return (addr[1:0] != 2'b00) || (last_byte >= 33'(rom_size));
  endfunction

endpackage

// File: rtl/rom_arb_picker.sv
// Winner selection between the fetch and load ports.
// Returns a one-hot grant: bit 0 = fetch, bit 1 = load.
module rom_arb_picker
  import rom_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       if_req,
  input  logic       ls_req,
  input  arb_port_e  last_owner,
  output logic [1:0] grant
);

  // On contention, round-robin favours whichever port did not win last time;
  // fixed priority always favours fetch.
  always_comb begin
    grant = 2'b00;
    if (if_req && ls_req) begin
      if ((ROUND_ROBIN != 0) && (last_owner == PORT_IF)) grant = 2'b10;
      else                                               grant = 2'b01;
    end else if (if_req) begin
      grant = 2'b01;
    end else if (ls_req) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port (fetch / load) arbiter in front of a single-ported ROM.
// One transaction in flight, three cycles each: grant, ROM read, response.
// Optional build macro ROM_ARB_ACCESS_CHECK_EN: misaligned or out-of-range
// accesses skip the ROM and return rdata=0 with err=1 at normal timing.
//
// state | meaning
// IDLE  | waiting for a request; grant issued combinationally here
// ISSUE | ROM strobe driven with the latched address
// RESP  | ROM data returned to the owner with rvalid
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ROM_SIZE    = 64000,
  parameter int          ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        rom_enable,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_data_out
);

  arb_state_e  state;
  arb_state_e  state_nxt;
  arb_port_e   owner;
  arb_port_e   last_owner;
  logic [1:0]  pick;
  logic        any_gnt;
  logic [31:0] sel_addr;
  logic        access_bad;
  logic        resp;
  logic [31:0] resp_data;
  logic [31:0] if_rdata_q;
  logic [31:0] ls_rdata_q;

  rom_arb_picker #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_picker (
    .if_req    (if_req),
    .ls_req    (ls_req),
    .last_owner(last_owner),
    .grant     (pick)
  );

  // Grants only in IDLE, and reset overrides any pending request.
  assign any_gnt  = (state == IDLE) && !reset && (pick != 2'b00);
  assign if_gnt   = any_gnt && pick[0];
  assign ls_gnt   = any_gnt && pick[1];
  assign sel_addr = pick[1] ? ls_addr : if_addr;

  // Next-state decode for the fixed three-cycle transaction.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick != 2'b00) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner tracking and address latch; rom_address doubles as the latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= PORT_IF;
      last_owner  <= PORT_LS;
      rom_address <= 32'h0;
    end else begin
      state <= state_nxt;
      if (any_gnt) begin
        owner       <= pick[1] ? PORT_LS : PORT_IF;
        last_owner  <= pick[1] ? PORT_LS : PORT_IF;
        rom_address <= sel_addr;
      end
    end
  end

`ifdef ROM_ARB_ACCESS_CHECK_EN
  logic bad_q;

  // Range/alignment verdict is taken on the same edge the address is latched.
  always_ff @(posedge clk) begin
    if (reset)        bad_q <= 1'b0;
    else if (any_gnt) bad_q <= addr_bad(sel_addr, ROM_SIZE);
  end

  assign access_bad = bad_q;
`else
  assign access_bad = 1'b0;
`endif

  assign rom_enable = (state == ISSUE) && !reset && !access_bad;

  assign resp      = (state == RESP) && !reset;
  assign resp_data = access_bad ? 32'h0 : rom_data_out;
  assign if_rvalid = resp && (owner == PORT_IF);
  assign ls_rvalid = resp && (owner == PORT_LS);
  assign if_err    = if_rvalid && access_bad;
  assign ls_err    = ls_rvalid && access_bad;

  // rdata shows the live response in RESP and the last delivered word otherwise.
  assign if_rdata = if_rvalid ? resp_data : if_rdata_q;
  assign ls_rdata = ls_rvalid ? resp_data : ls_rdata_q;

  // Per-port hold registers for the last delivered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata_q <= 32'h0;
      ls_rdata_q <= 32'h0;
    end else begin
      if (if_rvalid) if_rdata_q <= resp_data;
      if (ls_rvalid) ls_rdata_q <= resp_data;
    end
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ROM_SIZE, default 64000, ROM depth in bytes used for the range check.
REQ-002 Parameter ROUND_ROBIN, default 1: 1 = alternate on contention; 0 = fixed priority, fetch port wins.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch port request; held until if_gnt.
REQ-006 if_addr  in  32  fetch byte address, sampled in the if_gnt cycle.
REQ-007 if_gnt  out  1  one-cycle pulse: fetch request accepted.
REQ-008 if_rvalid  out  1  one-cycle pulse: if_rdata/if_err valid.
REQ-009 if_rdata  out  32  fetch read data, little-endian word.
REQ-010 if_err  out  1  fetch access error, qualified by if_rvalid.
REQ-011 ls_req, ls_addr, ls_gnt, ls_rvalid, ls_rdata, ls_err: load port, same widths and meaning as the if_* ports.
REQ-012 rom_enable  out  1  ROM read strobe.
REQ-013 rom_address  out  32  ROM byte address.
REQ-014 rom_data_out  in  32  ROM read data, valid one cycle after the enable edge.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE and RESP, one transaction in flight, and 3 cycles per transaction.
REQ-016 IDLE with any req: assert the winner's gnt combinationally in cycle N, latch owner and address at the end of N, go to ISSUE.
REQ-017 ISSUE (cycle N+1): rom_enable=1, rom_address=latched address; go to RESP.
REQ-018 RESP (cycle N+2): owner's rvalid=1, rdata=rom_data_out; go to IDLE.
REQ-019 gnt SHALL never assert outside IDLE; reqs in ISSUE/RESP are held off, not dropped.
REQ-020 At most one gnt and at most one rvalid SHALL be high per cycle.
REQ-021 Contention with ROUND_ROBIN=1: grant the port not granted most recently; last-owner resets to load, so fetch wins first.
REQ-022 Contention with ROUND_ROBIN=0: fetch always wins.
REQ-023 rdata SHALL hold its last value between rvalid pulses; the non-owner port's rvalid SHALL stay 0.
REQ-024 rom_enable SHALL be 0 outside ISSUE; rom_address SHALL hold its last value.

Reset
REQ-025 Reset SHALL dominate requests: next state IDLE; gnt, rvalid, err and rom_enable all 0; rdata and rom_address 0; last-owner = load.
REQ-026 Reset in ISSUE or RESP SHALL drop the transaction, with no rvalid afterwards.

Configuration
REQ-027 Macro ROM_ARB_ACCESS_CHECK_EN.
- Defined: a latched address with addr[1:0]!=0 or addr+3 >= ROM_SIZE SHALL suppress rom_enable in ISSUE; RESP then returns rdata=0, err=1, with the same timing.
- Undefined: no check; if_err and ls_err are tied to 0 and every access reaches the ROM.

Structure
REQ-028 Package rom_arb_pkg SHALL hold the state enum (IDLE/ISSUE/RESP), the owner enum (PORT_IF/PORT_LS), and the constants ROM_LATENCY=1 and WORD_BYTES=4.
REQ-029 The winner-select logic SHALL live in sub-module rom_arb_picker, which takes both reqs, last-owner and ROUND_ROBIN and returns a one-hot grant.

Verification
REQ-030 Single fetch: if_req=1, if_addr=0x0 at cycle 1 -> if_gnt cycle 1; rom_enable, rom_address=0x0 cycle 2; if_rvalid, if_rdata=0x03020100 cycle 3.
REQ-031 Contention, ROUND_ROBIN=1, both reqs held -> grants IF, LS, IF, LS, one every 3 cycles.
REQ-032 Contention, ROUND_ROBIN=0 -> IF granted every time while if_req is held; LS is starved.
REQ-033 Reset asserted in RESP -> no rvalid; the next cycle is IDLE with all outputs 0.
REQ-034 With ROM_ARB_ACCESS_CHECK_EN: ls_addr=0x2 -> no rom_enable, ls_rvalid=1, ls_err=1, ls_rdata=0; ls_addr=63997 -> same result.
REQ-035 A request arriving while busy -> held until IDLE, then granted; never lost or duplicated.
